// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream mux family.
package stream_mux_pkg;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  // Wrapped increment of a channel index in the range 0..n-1.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic              hit,
  output logic [SEL_W-1:0]  idx
);

  always_comb begin
    int base;
    int c;
    logic [SEL_W-1:0] cs;
    hit  = 1'b0;
    idx  = '0;
    base = (int'(ptr) < NUM_CH) ? int'(ptr) : 0;
    c    = 0;
    cs   = '0;
    // Walk from the farthest candidate back to ptr so the nearest hit is assigned last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = base + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      cs = SEL_W'(c);
      if (valid[cs]) begin
        hit = 1'b1;
        idx = cs;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 packet-aware round-robin stream mux with a one-stage registered output.
// Optional select override is enabled by defining STREAM_MUX_SEL_OVERRIDE_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
  input  logic                     sel_force_en,
  input  logic [SEL_W-1:0]         sel_force,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   rr_ptr, rr_d;
  logic [SEL_W-1:0]   lock_ch, lock_d;
  logic               lock_forced, forced_d;
  logic               pick_hit;
  logic [SEL_W-1:0]   pick_idx;
  logic               gnt_hit;
  logic [SEL_W-1:0]   gnt_idx;
  logic               force_pick;
  logic               can_load;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;

  rr_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  assign can_load = !out_valid || out_ready;

  always_comb begin
    gnt_hit    = 1'b0;
    gnt_idx    = '0;
    force_pick = 1'b0;
    if (state_q == ST_LOCK) begin
      gnt_hit = 1'b1;
      gnt_idx = lock_ch;
    end else begin
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
      if (sel_force_en) begin
        force_pick = 1'b1;
        gnt_idx    = sel_force;
        gnt_hit    = (int'(sel_force) < NUM_CH) && in_valid[sel_force];
      end else begin
        gnt_hit = pick_hit;
        gnt_idx = pick_idx;
      end
`else
      gnt_hit = pick_hit;
      gnt_idx = pick_idx;
`endif
    end
  end

  // Selection by index compare keeps X on non-granted channels away from the output.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = rst_n && can_load && gnt_hit;
        sel_data    = in_data[i*DATA_W +: DATA_W];
        sel_last    = in_last[i];
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_ptr;
    lock_d   = lock_ch;
    forced_d = lock_forced;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sel_last) begin
            if (!force_pick) rr_d = SEL_W'(rr_next(32'(gnt_idx), NUM_CH));
          end else begin
            state_d  = ST_LOCK;
            lock_d   = gnt_idx;
            forced_d = force_pick;
          end
        end
      end
      ST_LOCK: begin
        if (accept && sel_last) begin
          state_d = ST_IDLE;
          if (!lock_forced) rr_d = SEL_W'(rr_next(32'(lock_ch), NUM_CH));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr  <= rr_d;
      lock_ch <= lock_d;
    end
  end

`ifdef STREAM_MUX_SEL_OVERRIDE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_forced <= 1'b0;
    else        lock_forced <= forced_d;
  end
`else
  assign lock_forced = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4-channel DUT plus a 3-channel DUT for wrap checks.
module tb_stream_mux_rr;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic        out_last, out_valid, out_ready;
  logic [1:0]  out_ch;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_last3, out_valid3;
  logic [1:0]  out_ch3;

`ifdef STREAM_MUX_SEL_OVERRIDE_EN
  logic       sel_force_en4 = 1'b0;
  logic [1:0] sel_force4 = 2'd0;
  logic       sel_force_en3 = 1'b0;
  logic [1:0] sel_force3 = 2'd0;
`endif

  int checks = 0;
  int errors = 0;
  beat_t sb[$];
  beat_t exp_b;

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
    .sel_force_en(sel_force_en4), .sel_force(sel_force4),
`endif
    .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_last(in_last3), .in_ready(in_ready3),
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
    .sel_force_en(sel_force_en3), .sel_force(sel_force3),
`endif
    .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
    .out_valid(out_valid3), .out_ready(1'b1)
  );

  // Output monitor: every beat consumed by the sink must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got ch=%0d data=%h last=%b, expected no beat", out_ch, out_data, out_last);
      end else begin
        exp_b = sb.pop_front();
        if ({out_ch, out_data, out_last} !== {exp_b.ch, exp_b.data, exp_b.last}) begin
          errors++;
          $display("FAIL sb_beat got ch=%0d data=%h last=%b, expected ch=%0d data=%h last=%b",
                   out_ch, out_data, out_last, exp_b.ch, exp_b.data, exp_b.last);
        end
      end
    end
  end

  task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
    in_valid[ch]       = v;
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d, input logic l);
    beat_t b;
    b.ch = ch; b.data = d; b.last = l;
    sb.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h30201000;
    in_valid3 = '0; in_last3 = '0; in_data3 = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data, out_ch} !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs got ready=%b valid=%b data=%h ch=%0d, expected all zero",
                 in_ready, out_valid, out_data, out_ch);
      end
    end
    step();
    rst_n = 1'b1; in_valid = '0;
  endtask

  task automatic test_rr_single();
    logic [3:0] exp_r;
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 8'(c * 16), 1'b1);
    for (int k = 0; k < 5; k++) push(2'(k % 4), 8'((k % 4) * 16), 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_r = 4'(1 << (k % 4));
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL rr_grant beat %0d got ready=%b expected %b", k, in_ready, exp_r);
      end
      step();
    end
    in_valid = '0;
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain got %0d pending beats expected 0", sb.size());
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0] exp_r [5];
    exp_r = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    set_ch(0, 1'b0, 8'hxx, 1'bx);
    set_ch(3, 1'b0, 8'hxx, 1'bx);
    set_ch(1, 1'b1, 8'h11, 1'b0);
    set_ch(2, 1'b1, 8'h20, 1'b1);
    push(2'd1, 8'h11, 1'b0); push(2'd1, 8'h12, 1'b0);
    push(2'd1, 8'h13, 1'b1); push(2'd2, 8'h20, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== exp_r[k]) begin
        errors++;
        $display("FAIL lock_ready cycle %0d got ready=%b expected %b", k, in_ready, exp_r[k]);
      end
      step();
      case (k)
        0: in_valid[1] = 1'b0;
        1: set_ch(1, 1'b1, 8'h12, 1'b0);
        2: set_ch(1, 1'b1, 8'h13, 1'b1);
        3: in_valid[1] = 1'b0;
        default: in_valid[2] = 1'b0;
      endcase
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL lock_drain got %0d pending beats expected 0", sb.size());
    end
    in_data = '0; in_last = '0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    set_ch(3, 1'b1, 8'h30, 1'b0);
    for (int k = 0; k < 4; k++) push(2'd3, 8'(8'h30 + k), (k == 3));
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_first_ready got %b expected 1000", in_ready);
    end
    step();
    set_ch(3, 1'b1, 8'h31, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data, out_ch, out_last} !== {4'b0000, 1'b1, 8'h30, 2'd3, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ready=%b valid=%b data=%h ch=%0d last=%b, expected 0000 1 30 3 0",
                 k, in_ready, out_valid, out_data, out_ch, out_last);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b1000) begin
        errors++;
        $display("FAIL bp_resume beat %0d got ready=%b expected 1000", k, in_ready);
      end
      step();
      if (k < 3) set_ch(3, 1'b1, 8'(8'h31 + k), (k == 2));
      else in_valid[3] = 1'b0;
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d pending beats expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    set_ch(3, 1'b1, 8'h40, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_first_ready got %b expected 1000", in_ready);
    end
    step();
    rst_n = 1'b0;
    set_ch(0, 1'b1, 8'h50, 1'b1);
    set_ch(3, 1'b1, 8'h41, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 5'd0) begin
        errors++;
        $display("FAIL rstmid_hold got valid=%b ready=%b expected 0 0000", out_valid, in_ready);
      end
      step();
    end
    rst_n = 1'b1;
    push(2'd0, 8'h50, 1'b1); push(2'd3, 8'h41, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_grant0 got ready=%b expected 0001", in_ready);
    end
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_grant3 got ready=%b expected 1000", in_ready);
    end
    step();
    in_valid[3] = 1'b0;
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rstmid_drain got %0d pending beats expected 0", sb.size());
    end
  endtask

  task automatic test_wrap3();
    logic [2:0] exp_r;
    in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 24'h201000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_r = 3'(1 << (k % 3));
      checks++;
      if (in_ready3 !== exp_r) begin
        errors++;
        $display("FAIL wrap3_grant beat %0d got ready=%b expected %b", k, in_ready3, exp_r);
      end
      if (k > 0) begin
        checks++;
        if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'((k - 1) % 3), 8'(((k - 1) % 3) * 16)}) begin
          errors++;
          $display("FAIL wrap3_out beat %0d got valid=%b ch=%0d data=%h expected 1 %0d %h",
                   k, out_valid3, out_ch3, out_data3, (k - 1) % 3, ((k - 1) % 3) * 16);
        end
      end
      step();
    end
    in_valid3 = '0;
    @(negedge clk);
    checks++;
    if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'd0, 8'h00}) begin
      errors++;
      $display("FAIL wrap3_final got valid=%b ch=%0d data=%h expected 1 0 00", out_valid3, out_ch3, out_data3);
    end
    step();
  endtask

`ifdef STREAM_MUX_SEL_OVERRIDE_EN
  task automatic test_override();
    in_valid3 = 3'b111; in_last3 = 3'b111;
    sel_force_en3 = 1'b1; sel_force3 = 2'd2;
    @(negedge clk);
    checks++;
    if (in_ready3 !== 3'b100) begin
      errors++;
      $display("FAIL force_ch2 got ready=%b expected 100", in_ready3);
    end
    sel_force3 = 2'd3;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      errors++;
      $display("FAIL force_oob got ready=%b expected 000", in_ready3);
    end
    in_valid3 = '0; sel_force_en3 = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_rr_single();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_wrap3();
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
    test_override();
`endif
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
